// File: rtl/simon_wb_ctrl.sv
// Wishbone slave register block for the Simon Says macro: control, tick divider,
// score readout and a button-event FIFO whose non-empty state drives the user IRQ.
module simon_wb_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        btn_valid_i,
    input  logic [1:0]  btn_id_i,
    input  logic [7:0]  score_i,
    output logic        enable_o,
    output logic        start_o,
    output logic [15:0] tick_div_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_TICK   = 6'h01;
    localparam logic [5:0] OFF_STATUS = 6'h02;
    localparam logic [5:0] OFF_EVENT  = 6'h03;
    localparam logic [5:0] OFF_SCORE  = 6'h04;

    logic        req, in_win, rd, wr;
    logic [5:0]  off;
    logic        irq_en, overflow;
    logic [AW:0] wptr, rptr, count;
    logic        empty, full, push, pop, ovf_set, ovf_clr;
    logic [31:0] rdata;
    logic [1:0]  mem [FIFO_DEPTH];

    // A strobe still high during its own ack cycle is not a new request.
    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign in_win = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off    = wbs_adr_i[7:2];
    assign rd     = req & in_win & ~wbs_we_i;
    assign wr     = req & in_win & wbs_we_i;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == DEPTH_L);
    assign pop     = rd & (off == OFF_EVENT) & ~empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is accepted.
    assign push    = btn_valid_i & (~full | pop);
    assign ovf_set = btn_valid_i & full & ~pop;
    assign ovf_clr = wr & (off == OFF_STATUS) & wbs_sel_i[1] & wbs_dat_i[10];

    always_comb begin
        // NOTE: every path of an always_comb must assign its outputs; defaulting first rules out latches.
        rdata = '0;
        if (in_win) begin
            case (off)
                OFF_CTRL:   rdata = {29'b0, irq_en, 1'b0, enable_o};
                OFF_TICK:   rdata = {16'b0, tick_div_o};
                OFF_STATUS: rdata = {21'b0, overflow, full, empty, 3'b0, 5'(count)};
                OFF_EVENT:  rdata = empty ? 32'h0 : {1'b1, 29'b0, mem[rptr[AW-1:0]]};
                OFF_SCORE:  rdata = {24'b0, score_i};
                default:    rdata = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            enable_o   <= 1'b0;
            start_o    <= 1'b0;
            irq_en     <= 1'b0;
            tick_div_o <= 16'h03E8;
            overflow   <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            irq_o      <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
            start_o   <= wr & (off == OFF_CTRL) & wbs_sel_i[0] & wbs_dat_i[1];
            if (wr && off == OFF_CTRL && wbs_sel_i[0]) begin
                enable_o <= wbs_dat_i[0];
                irq_en   <= wbs_dat_i[2];
            end
            if (wr && off == OFF_TICK) begin
                if (wbs_sel_i[0]) tick_div_o[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) tick_div_o[15:8] <= wbs_dat_i[15:8];
            end
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            irq_o <= irq_en & ~empty;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wptr[AW-1:0]] <= btn_id_i;
    end

    logic unused;
    assign unused = &{1'b0, wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:16]};

endmodule

// File: tb/tb_simon_wb_ctrl.sv
// Self-checking bench for simon_wb_ctrl: expected read data is queued when a read
// is issued and compared when the ack arrives; FIFO contents come from a queue model.
module tb_simon_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        btn_valid = 1'b0;
    logic [1:0]  btn_id = 2'd0;
    logic [7:0]  score = 8'h5A;
    logic        enable, start, irq;
    logic [15:0] tick_div;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [31:0] sb[$];
    logic [1:0]  ev_q[$];
    bit          ovf_m = 0;

    localparam int DEPTH = 8;

    simon_wb_ctrl dut (
        .wb_clk_i(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .btn_valid_i(btn_valid), .btn_id_i(btn_id), .score_i(score),
        .enable_o(enable), .start_o(start), .tick_div_o(tick_div), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (start) start_cnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = ev_q.size();
        return {21'b0, ovf_m, (n == DEPTH), (n == 0), 3'b0, 5'(n)};
    endfunction

    function automatic logic [31:0] exp_event();
        return (ev_q.size() == 0) ? 32'h0 : {1'b1, 29'b0, ev_q[0]};
    endfunction

    // One bus cycle; optionally raises a button event on the same edge as the request.
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input bit with_push, input string tag);
        int  waited = 0;
        bit  got = 0;
        logic [31:0] e;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        if (with_push) begin btn_valid = 1'b1; btn_id = 2'd3; end
        while (!got && waited < 8) begin
            @(negedge clk);
            waited++;
            btn_valid = 1'b0;
            if (ack) got = 1;
        end
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
            if (!w) void'(sb.pop_front());
        end else begin
            check({tag, "_lat"}, waited, 1);
            if (!w) begin
                e = sb.pop_front();
                check(tag, rdat, e);
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle"}, {ack, rdat}, 33'h0);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input string tag);
        wb_cycle(a, 1'b1, d, s, 1'b0, tag);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string tag);
        sb.push_back(e);
        wb_cycle(a, 1'b0, 32'h0, 4'hF, 1'b0, tag);
    endtask

    task automatic btn_push(input logic [1:0] id);
        @(negedge clk);
        btn_valid = 1'b1; btn_id = id;
        if (ev_q.size() < DEPTH) ev_q.push_back(id);
        else ovf_m = 1;
    endtask

    task automatic btn_idle();
        @(negedge clk);
        btn_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dat", rdat, 0);
        check("rst_outs", {enable, start, irq}, 3'b000);
        check("rst_tick", tick_div, 16'h03E8);
        rst_n = 1'b1;

        wb_read(32'h3000_0004, 32'h0000_03E8, "rd_tick_rst");
        wb_read(32'h3000_0000, 32'h0, "rd_ctrl_rst");
        wb_read(32'h3000_0008, exp_status(), "rd_status_rst");

        // Byte-lane gated tick divider writes
        wb_write(32'h3000_0004, 32'hABCD_1234, 4'b0001, "wr_tick_b0");
        check("tick_b0", tick_div, 16'h0334);
        wb_write(32'h3000_0004, 32'hABCD_1234, 4'b0011, "wr_tick_b01");
        check("tick_b01", tick_div, 16'h1234);
        wb_read(32'h3000_0004, 32'h0000_1234, "rd_tick");

        // CTRL: enable, start pulse, irq_en
        check("start_none", start_cnt, 0);
        wb_write(32'h3000_0000, 32'h7, 4'b0001, "wr_ctrl");
        repeat (2) @(negedge clk);
        check("start_once", start_cnt, 1);
        check("enable", enable, 1);
        wb_read(32'h3000_0000, 32'h5, "rd_ctrl");
        score = 8'hC3;
        wb_read(32'h3000_0010, 32'h0000_00C3, "rd_score");

        // Three events, IRQ latency and pop order
        check("irq_idle", irq, 0);
        btn_push(2'd2);
        btn_idle();
        check("irq_lat0", irq, 0);
        @(negedge clk);
        check("irq_lat1", irq, 1);
        btn_push(2'd1);
        btn_push(2'd3);
        btn_idle();
        wb_read(32'h3000_0008, exp_status(), "rd_status_3");
        for (int i = 0; i < 4; i++) begin
            wb_read(32'h3000_000C, exp_event(), $sformatf("rd_event_%0d", i));
            if (ev_q.size() > 0) void'(ev_q.pop_front());
        end
        @(negedge clk);
        check("irq_drained", irq, 0);

        // Fill past full: overflow, W1C, pop+push while full
        for (int i = 0; i < 9; i++) btn_push(2'(i));
        btn_idle();
        wb_read(32'h3000_0008, 32'h0000_0608, "rd_status_ovf");
        check("irq_full", irq, 1);
        wb_write(32'h3000_0008, 32'h0000_0400, 4'b0010, "wr_status_w1c");
        ovf_m = 0;
        wb_read(32'h3000_0008, exp_status(), "rd_status_clr");
        sb.push_back(exp_event());
        void'(ev_q.pop_front());
        ev_q.push_back(2'd3);
        wb_cycle(32'h3000_000C, 1'b0, 32'h0, 4'hF, 1'b1, "rd_event_pushpop");
        wb_read(32'h3000_0008, 32'h0000_0208, "rd_status_pushpop");
        while (ev_q.size() > 0) begin
            wb_read(32'h3000_000C, exp_event(), $sformatf("drain_%0d", ev_q.size()));
            void'(ev_q.pop_front());
        end
        wb_read(32'h3000_0008, exp_status(), "rd_status_empty");

        // Out-of-window and unmapped offsets
        wb_write(32'h3000_0100, 32'h0, 4'hF, "wr_oow");
        wb_read(32'h3000_0100, 32'h0, "rd_oow");
        wb_write(32'h3000_0014, 32'hFFFF_FFFF, 4'hF, "wr_unmapped");
        wb_read(32'h3000_0014, 32'h0, "rd_unmapped");
        check("oow_regs", {enable, tick_div}, {1'b1, 16'h1234});
        check("oow_nostart", start_cnt, 1);

        // Reset during a pending strobe
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0004; sel = 4'hF;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("abort_ack", ack, 0);
        cyc = 1'b0; stb = 1'b0;
        ev_q.delete(); ovf_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_noack", ack, 0);
        check("abort_regs", {enable, irq, tick_div}, {1'b0, 1'b0, 16'h03E8});
        wb_read(32'h3000_0000, 32'h0, "rd_ctrl_abort");
        wb_read(32'h3000_0008, exp_status(), "rd_status_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/simon_wb_ctrl.md
Name: simon_wb_ctrl

Overview:
- Wishbone slave register block for the Simon Says macro; sits directly downstream of the user_project_wrapper Wishbone/IRQ ports.
- Exposes control and tick-divider registers and a score readout to the management SoC.
- Buffers button-press events from the game core in a small FIFO that firmware drains.
- Raises a user IRQ while events are pending.

Parameters:
- BASE_ADDR, 32'h3000_0000, register window base; decode compares adr[31:8] against BASE_ADDR[31:8].
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, range 2..16.

Ports:
- wb_clk_i  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_stb_i  input  1  Wishbone strobe
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte selects
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- btn_valid_i  input  1  one-cycle button event strobe from the game core
- btn_id_i  input  2  button index (0..3)
- score_i  input  8  current game score
- enable_o  output  1  game enable (CTRL[0])
- start_o  output  1  one-cycle game start pulse
- tick_div_o  output  16  game tick divider
- irq_o  output  1  event-pending interrupt; the wrapper drives user_irq[0] from it

Behaviour:
- Reset (rst_n low, asynchronous): all outputs clear except tick_div_o.
  - wbs_ack_o=0, wbs_dat_o=0, enable_o=0, start_o=0, irq_o=0.
  - tick_div_o=16'h03E8.
  - FIFO empty, overflow flag = 0, irq_en = 0.
- Bus handshake:
  - A request is cyc&stb&!ack_o. wbs_ack_o goes high on the next edge and stays high exactly one cycle.
  - wbs_dat_o is registered and valid in the ack cycle; it is 0 outside ack cycles.
  - A strobe held through the ack cycle is ignored that cycle, so a continuous strobe yields acks every second cycle.
- Out-of-window or unmapped offsets: acked, read 0, write ignored. Never stall.
- Registers are selected by adr[7:0]; adr[1:0] are ignored.
  - 0x00 CTRL, RW.
    - Bit0 = enable; bit2 = irq_en.
    - Bit1 is write-1 start: it pulses start_o for one cycle, the cycle after the write is acked internally (same edge as ack), and reads as 0.
    - Writes apply only when sel[0]=1.
  - 0x04 TICK_DIV, RW, bits[15:0]. sel[0] gates bits[7:0]; sel[1] gates bits[15:8]. Upper bits read 0.
  - 0x08 STATUS, RO except W1C.
    - [4:0] = fifo count; bit8 = empty; bit9 = full; bit10 = overflow (sticky).
    - A write with bit10=1 and sel[1]=1 clears overflow.
  - 0x0C EVENT, read-to-pop.
    - Non-empty: returns {1'b1 at bit31, 29'b0, id[1:0]} and pops the head entry.
    - Empty: returns 0 and pops nothing.
    - Writes are ignored.
  - 0x10 SCORE, RO, {24'b0, score_i} sampled at the ack edge.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address; count = wptr - rptr.
  - Push on btn_valid_i when not full.
  - Push while full: event dropped, overflow set. If an EVENT pop occurs on the same edge, the push is accepted instead and overflow is not set.
  - Simultaneous push and pop on an empty FIFO: the read returns 0 and the push is stored; count becomes 1.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- irq_o is registered: irq_en & !empty, with one cycle of latency from the FIFO state change.
- Reset asserted mid-transaction aborts it. No ack is issued after release for the aborted cycle; the master must retry.

Test Plan:
- Reset, then read 0x04, 0x00, 0x08 -> 0x03E8, 0x0, 0x100. Every ack is exactly 1 cycle wide, 1 cycle after stb.
- Write 0x04=0xABCD1234 with sel=4'b0001 -> tick_div_o=0x0334. Then sel=4'b0011 -> 0x1234, and readback is 0x00001234.
- Write CTRL=0x7 -> enable_o=1, a single start_o pulse, irq_en=1. Readback is 0x5.
- Pulse btn_valid_i with ids 2,1,3 -> STATUS count=3, irq_o high one cycle after the first push. EVENT reads return 0x80000002, 0x80000001, 0x80000003, then 0x0. irq_o drops after the last pop.
- Push 9 events with FIFO_DEPTH=8 -> STATUS=0x600|8 (full+overflow). Write STATUS 0x400 -> overflow clears. With full FIFO, EVENT read and push on the same edge -> count stays 8, no overflow.
- Access adr 0x3000_0100 and offset 0x14 -> acked, read 0, no register changes. Assert rst_n low during a pending strobe -> no ack, and all registers return to reset values.
